// File: rtl/branch_resolve_unit.sv
// Branch resolution FSM: holds decode for a fixed number of stall cycles, then
// waits for valid flags, resolves the ccc condition and counts taken/not-taken.
module branch_resolve_unit #(
  parameter int         STALL_CYCLES = 1,
  parameter int         CNT_W        = 16,
  parameter logic [3:0] B_OP         = 4'hC,
  parameter logic [3:0] BR_OP        = 4'hD
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       opcode,
  input  logic [2:0]       C,
  input  logic [2:0]       flags,
  input  logic             flags_valid,
  input  logic             flush,
  output logic             stall_en,
  output logic             take_branch,
  output logic             branch_done,
  output logic [CNT_W-1:0] taken_cnt,
  output logic [CNT_W-1:0] not_taken_cnt,
  output logic [1:0]       o_dbg_state
);

  // Stall counter only ever holds values up to STALL_CYCLES-1.
  localparam int SC_W = (STALL_CYCLES > 1) ? $clog2(STALL_CYCLES) : 1;
  localparam logic [SC_W-1:0]  SC_LOAD = SC_W'(STALL_CYCLES - 1);
  localparam logic [SC_W-1:0]  SC_ONE  = SC_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_STALL = 2'd1,
    S_EVAL  = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_next_state;
  logic [SC_W-1:0]  r_scnt;
  logic [SC_W-1:0]  w_scnt_next;
  logic [CNT_W-1:0] r_taken_cnt;
  logic [CNT_W-1:0] r_not_taken_cnt;
  logic             w_is_br;
  logic             w_cond_met;
  logic             w_z;
  logic             w_v;
  logic             w_n;

  assign w_z     = flags[2];
  assign w_v     = flags[1];
  assign w_n     = flags[0];
  assign w_is_br = (opcode == B_OP) | (opcode == BR_OP);

  always_comb begin
    w_cond_met = 1'b0;
    case (C)
      3'b000:  w_cond_met = ~w_z;
      3'b001:  w_cond_met = w_z;
      3'b010:  w_cond_met = ~w_z & ~w_n;
      3'b011:  w_cond_met = w_n;
      3'b100:  w_cond_met = w_z | (~w_z & ~w_n);
      3'b101:  w_cond_met = w_n | w_z;
      3'b110:  w_cond_met = w_v;
      default: w_cond_met = 1'b1;
    endcase
  end

  // rst and flush both silence the outputs; a squash (is_br dropping) returns to IDLE quietly.
  always_comb begin
    w_next_state = r_state;
    w_scnt_next  = r_scnt;
    stall_en     = 1'b0;
    take_branch  = 1'b0;
    branch_done  = 1'b0;
    if (rst || flush) begin
      w_next_state = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_is_br) begin
            stall_en     = 1'b1;
            w_scnt_next  = SC_LOAD;
            w_next_state = (STALL_CYCLES == 1) ? S_EVAL : S_STALL;
          end
        end
        S_STALL: begin
          if (!w_is_br) begin
            w_next_state = S_IDLE;
          end else begin
            stall_en    = 1'b1;
            w_scnt_next = r_scnt - SC_ONE;
            if (r_scnt == SC_ONE) w_next_state = S_EVAL;
          end
        end
        S_EVAL: begin
          if (!w_is_br) begin
            w_next_state = S_IDLE;
          end else if (flags_valid || (C == 3'b111)) begin
            branch_done  = 1'b1;
            take_branch  = w_cond_met;
            w_next_state = S_IDLE;
          end else begin
            stall_en = 1'b1;
          end
        end
        default: w_next_state = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state         <= S_IDLE;
      r_scnt          <= '0;
      r_taken_cnt     <= '0;
      r_not_taken_cnt <= '0;
    end else begin
      r_state <= w_next_state;
      r_scnt  <= w_scnt_next;
      // Statistics saturate at all-ones.
      if (branch_done) begin
        if (take_branch) begin
          if (r_taken_cnt != '1) r_taken_cnt <= r_taken_cnt + CNT_ONE;
        end else begin
          if (r_not_taken_cnt != '1) r_not_taken_cnt <= r_not_taken_cnt + CNT_ONE;
        end
      end
    end
  end

  assign taken_cnt     = r_taken_cnt;
  assign not_taken_cnt = r_not_taken_cnt;
  assign o_dbg_state   = r_state;

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed bench for branch_resolve_unit: three instances (stall 1/16-bit,
// stall 3/2-bit counters, stall 2/16-bit) share inputs; each test checks one.
module tb_branch_resolve_unit;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_STALL = 2'd1;
  localparam logic [1:0] ST_EVAL  = 2'd2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] opcode = 4'h0;
  logic [2:0] c_in = 3'b000;
  logic [2:0] flags = 3'b000;
  logic       flags_valid = 1'b0;
  logic       flush = 1'b0;

  logic        a_stall, a_take, a_done;
  logic [15:0] a_tcnt, a_ncnt;
  logic [1:0]  a_state;
  logic        b_stall, b_take, b_done;
  logic [1:0]  b_tcnt, b_ncnt;
  logic [1:0]  b_state;
  logic        c_stall, c_take, c_done;
  logic [15:0] c_tcnt, c_ncnt;
  logic [1:0]  c_state;

  logic [2:0] a_o, b_o, c_o;
  assign a_o = {a_stall, a_take, a_done};
  assign b_o = {b_stall, b_take, b_done};
  assign c_o = {c_stall, c_take, c_done};

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  branch_resolve_unit #(.STALL_CYCLES(1), .CNT_W(16)) u_dut (
    .clk(clk), .rst(rst), .opcode(opcode), .C(c_in), .flags(flags),
    .flags_valid(flags_valid), .flush(flush), .stall_en(a_stall),
    .take_branch(a_take), .branch_done(a_done), .taken_cnt(a_tcnt),
    .not_taken_cnt(a_ncnt), .o_dbg_state(a_state)
  );

  branch_resolve_unit #(.STALL_CYCLES(3), .CNT_W(2)) u_s3 (
    .clk(clk), .rst(rst), .opcode(opcode), .C(c_in), .flags(flags),
    .flags_valid(flags_valid), .flush(flush), .stall_en(b_stall),
    .take_branch(b_take), .branch_done(b_done), .taken_cnt(b_tcnt),
    .not_taken_cnt(b_ncnt), .o_dbg_state(b_state)
  );

  branch_resolve_unit #(.STALL_CYCLES(2), .CNT_W(16)) u_s2 (
    .clk(clk), .rst(rst), .opcode(opcode), .C(c_in), .flags(flags),
    .flags_valid(flags_valid), .flush(flush), .stall_en(c_stall),
    .take_branch(c_take), .branch_done(c_done), .taken_cnt(c_tcnt),
    .not_taken_cnt(c_ncnt), .o_dbg_state(c_state)
  );

  // Inputs change 1 time unit after the rising edge; checks happen on the falling edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; opcode = 4'h0; c_in = 3'b000; flags = 3'b000;
    flags_valid = 1'b0; flush = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; opcode = 4'hC; c_in = 3'b111; flags_valid = 1'b1;
    @(negedge clk);
    n_tests++;
    if (a_o !== 3'b000) begin
      n_fail++; $display("FAIL reset_outputs got %b want 000", a_o);
    end
    tick();
    @(negedge clk);
    n_tests++;
    if (a_state !== ST_IDLE || a_tcnt !== 16'd0 || a_ncnt !== 16'd0) begin
      n_fail++; $display("FAIL reset_state state=%0d t=%0d n=%0d want 0/0/0", a_state, a_tcnt, a_ncnt);
    end
    rst = 1'b0; opcode = 4'h0;
    @(negedge clk);
    n_tests++;
    if (a_o !== 3'b000) begin
      n_fail++; $display("FAIL idle_nobr got %b want 000", a_o);
    end
    tick();
  endtask

  task automatic test_taken_s1();
    do_reset();
    opcode = 4'hC; c_in = 3'b001; flags = 3'b100; flags_valid = 1'b1;
    @(negedge clk);
    n_tests++;
    if (a_o !== 3'b100) begin
      n_fail++; $display("FAIL s1_cycle0 got %b want 100", a_o);
    end
    tick();
    @(negedge clk);
    n_tests++;
    if (a_o !== 3'b011) begin
      n_fail++; $display("FAIL s1_cycle1 got %b want 011", a_o);
    end
    tick();
    opcode = 4'h0;
    @(negedge clk);
    n_tests++;
    if (a_o !== 3'b000 || a_tcnt !== 16'd1 || a_ncnt !== 16'd0) begin
      n_fail++; $display("FAIL s1_count out=%b t=%0d n=%0d want 000/1/0", a_o, a_tcnt, a_ncnt);
    end
    tick();
  endtask

  task automatic test_not_taken_s3();
    do_reset();
    opcode = 4'hD; c_in = 3'b000; flags = 3'b100; flags_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      n_tests++;
      if (b_o !== ((k < 3) ? 3'b100 : 3'b001)) begin
        n_fail++; $display("FAIL s3_cycle%0d got %b want %b", k, b_o, (k < 3) ? 3'b100 : 3'b001);
      end
      tick();
    end
    opcode = 4'h0;
    @(negedge clk);
    n_tests++;
    if (b_ncnt !== 2'd1 || b_tcnt !== 2'd0 || b_state !== ST_IDLE) begin
      n_fail++; $display("FAIL s3_count t=%0d n=%0d st=%0d want 0/1/0", b_tcnt, b_ncnt, b_state);
    end
    tick();
  endtask

  task automatic test_flag_wait();
    do_reset();
    opcode = 4'hC; c_in = 3'b011; flags = 3'b001; flags_valid = 1'b0;
    for (int k = 0; k < 6; k++) begin
      if (k == 5) flags_valid = 1'b1;
      @(negedge clk);
      n_tests++;
      if (a_o !== ((k < 5) ? 3'b100 : 3'b011)) begin
        n_fail++; $display("FAIL wait_cycle%0d got %b want %b", k, a_o, (k < 5) ? 3'b100 : 3'b011);
      end
      if (k == 3) begin
        n_tests++;
        if (a_state !== ST_EVAL) begin
          n_fail++; $display("FAIL wait_state got %0d want %0d", a_state, ST_EVAL);
        end
      end
      tick();
    end
    opcode = 4'h0;
    @(negedge clk);
    n_tests++;
    if (a_tcnt !== 16'd1) begin
      n_fail++; $display("FAIL wait_count got %0d want 1", a_tcnt);
    end
    tick();
  endtask

  task automatic test_always();
    do_reset();
    opcode = 4'hC; c_in = 3'b111; flags = 3'b000; flags_valid = 1'b0;
    tick();
    @(negedge clk);
    n_tests++;
    if (a_o !== 3'b011) begin
      n_fail++; $display("FAIL always_eval got %b want 011", a_o);
    end
    tick();
    opcode = 4'h0;
  endtask

  task automatic test_flush_stall();
    do_reset();
    opcode = 4'hD; c_in = 3'b111; flags_valid = 1'b1;
    @(negedge clk);
    n_tests++;
    if (c_o !== 3'b100) begin
      n_fail++; $display("FAIL flush_start got %b want 100", c_o);
    end
    tick();
    flush = 1'b1;
    @(negedge clk);
    n_tests++;
    if (c_o !== 3'b000 || c_state !== ST_STALL) begin
      n_fail++; $display("FAIL flush_cycle out=%b st=%0d want 000/%0d", c_o, c_state, ST_STALL);
    end
    tick();
    flush = 1'b0;
    @(negedge clk);
    n_tests++;
    if (c_state !== ST_IDLE || c_o !== 3'b100 || c_tcnt !== 16'd0 || c_ncnt !== 16'd0) begin
      n_fail++; $display("FAIL flush_after st=%0d out=%b t=%0d n=%0d want 0/100/0/0", c_state, c_o, c_tcnt, c_ncnt);
    end
    tick();
    opcode = 4'h0;
  endtask

  task automatic test_squash();
    do_reset();
    opcode = 4'hD; c_in = 3'b111; flags_valid = 1'b1;
    tick();
    opcode = 4'h3;
    @(negedge clk);
    n_tests++;
    if (c_o !== 3'b000) begin
      n_fail++; $display("FAIL squash_cycle got %b want 000", c_o);
    end
    tick();
    @(negedge clk);
    n_tests++;
    if (c_state !== ST_IDLE || c_tcnt !== 16'd0 || c_ncnt !== 16'd0) begin
      n_fail++; $display("FAIL squash_after st=%0d t=%0d n=%0d want 0/0/0", c_state, c_tcnt, c_ncnt);
    end
    opcode = 4'h0;
    tick();
  endtask

  task automatic test_mid_c_change();
    do_reset();
    opcode = 4'hC; c_in = 3'b000; flags = 3'b100; flags_valid = 1'b1;
    tick(); tick(); tick();
    c_in = 3'b001;
    @(negedge clk);
    n_tests++;
    if (b_o !== 3'b011) begin
      n_fail++; $display("FAIL c_change got %b want 011", b_o);
    end
    tick();
    opcode = 4'h0;
  endtask

  task automatic test_back_to_back_sat();
    logic [2:0] exp_o;
    do_reset();
    opcode = 4'hC; c_in = 3'b111; flags_valid = 1'b1;
    for (int k = 0; k < 20; k++) begin
      exp_o = ((k % 4) == 3) ? 3'b011 : 3'b100;
      @(negedge clk);
      n_tests++;
      if (b_o !== exp_o) begin
        n_fail++; $display("FAIL b2b_cycle%0d got %b want %b", k, b_o, exp_o);
      end
      tick();
    end
    opcode = 4'h0;
    @(negedge clk);
    n_tests++;
    if (b_tcnt !== 2'd3 || b_ncnt !== 2'd0) begin
      n_fail++; $display("FAIL saturate t=%0d n=%0d want 3/0", b_tcnt, b_ncnt);
    end
    tick();
  endtask

  task automatic test_cond_table();
    // Packed as {C, flags{Z,V,N}, expected take}.
    logic [6:0] vec [15] = '{
      7'b000_000_1, 7'b000_100_0, 7'b001_100_1, 7'b010_000_1, 7'b010_001_0,
      7'b011_001_1, 7'b011_000_0, 7'b100_100_1, 7'b100_001_0, 7'b101_100_1,
      7'b101_000_0, 7'b110_010_1, 7'b110_101_0, 7'b111_000_1, 7'b001_000_0
    };
    int exp_t;
    int exp_n;
    exp_t = 0;
    exp_n = 0;
    do_reset();
    flags_valid = 1'b1;
    for (int i = 0; i < 15; i++) begin
      opcode = (i % 2 == 0) ? 4'hC : 4'hD;
      c_in = vec[i][6:4];
      flags = vec[i][3:1];
      @(negedge clk);
      n_tests++;
      if (a_o !== 3'b100) begin
        n_fail++; $display("FAIL cond%0d_idle got %b want 100", i, a_o);
      end
      tick();
      @(negedge clk);
      n_tests++;
      if (a_o !== {1'b0, vec[i][0], 1'b1}) begin
        n_fail++; $display("FAIL cond%0d_eval got %b want %b", i, a_o, {1'b0, vec[i][0], 1'b1});
      end
      if (vec[i][0]) exp_t++; else exp_n++;
      tick();
    end
    opcode = 4'h0;
    @(negedge clk);
    n_tests++;
    if (a_tcnt !== 16'(exp_t) || a_ncnt !== 16'(exp_n)) begin
      n_fail++; $display("FAIL cond_counts t=%0d n=%0d want %0d/%0d", a_tcnt, a_ncnt, exp_t, exp_n);
    end
    tick();
  endtask

  task automatic test_rst_eval();
    do_reset();
    opcode = 4'hC; c_in = 3'b111; flags_valid = 1'b1;
    tick(); tick();
    c_in = 3'b000; flags = 3'b100; flags_valid = 1'b0;
    tick();
    rst = 1'b1;
    @(negedge clk);
    n_tests++;
    if (a_o !== 3'b000 || a_state !== ST_EVAL || a_tcnt !== 16'd1) begin
      n_fail++; $display("FAIL rst_eval out=%b st=%0d t=%0d want 000/%0d/1", a_o, a_state, a_tcnt, ST_EVAL);
    end
    tick();
    rst = 1'b0; opcode = 4'h0;
    @(negedge clk);
    n_tests++;
    if (a_tcnt !== 16'd0 || a_ncnt !== 16'd0 || a_state !== ST_IDLE) begin
      n_fail++; $display("FAIL rst_after t=%0d n=%0d st=%0d want 0/0/0", a_tcnt, a_ncnt, a_state);
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_taken_s1();
    test_not_taken_s3();
    test_flag_wait();
    test_always();
    test_flush_stall();
    test_squash();
    test_mid_c_change();
    test_back_to_back_sat();
    test_cond_table();
    test_rst_eval();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/branch_resolve_unit.md
BRANCH_RESOLVE_UNIT -- requirements
Module: branch_resolve_unit

Interface
REQ-001 Parameter STALL_CYCLES, default 1, meaning the number of fixed stall cycles before a B/BR is evaluated (legal range >=1).
REQ-002 Parameter CNT_W, default 16, meaning the width of the taken and not-taken statistics counters.
REQ-003 Parameter B_OP, default 4'hC, meaning the B opcode.
REQ-004 Parameter BR_OP, default 4'hD, meaning the BR opcode.
REQ-005 Port clk, input, 1 bit, meaning the single clock; all state updates on the rising edge.
REQ-006 Port rst, input, 1 bit, meaning the reset; synchronous and active-high.
REQ-007 Port opcode, input, 4 bits, meaning the opcode of the instruction held in decode.
REQ-008 Port C, input, 3 bits, meaning the ccc condition code.
REQ-009 Port flags, input, 3 bits, meaning {Z,V,N}: Z=flags[2], V=flags[1], N=flags[0].
REQ-010 Port flags_valid, input, 1 bit, meaning that no in-flight flag writer is pending and flags are current.
REQ-011 Port flush, input, 1 bit, meaning a synchronous abort of any branch in progress.
REQ-012 Port stall_en, output, 1 bit, meaning hold fetch/decode this cycle.
REQ-013 Port take_branch, output, 1 bit, meaning redirect the PC this cycle (1-cycle pulse).
REQ-014 Port branch_done, output, 1 bit, meaning the branch resolved this cycle, whether taken or not.
REQ-015 Port taken_cnt, output, CNT_W bits, meaning the count of resolved taken branches.
REQ-016 Port not_taken_cnt, output, CNT_W bits, meaning the count of resolved not-taken branches.

Function
REQ-017 is_br SHALL equal (opcode==B_OP) | (opcode==BR_OP).
REQ-018 cond_met SHALL be decoded from C as follows: 000 Z=0; 001 Z=1; 010 Z=0&N=0; 011 N=1; 100 Z=1|(Z=0&N=0); 101 N=1|Z=1; 110 V=1; 111 always.
REQ-019 The FSM SHALL have the states IDLE, STALL, EVAL; the state after reset is IDLE.
REQ-020 In IDLE with is_br=1, stall_en SHALL be 1 in the same cycle (combinational).
REQ-021 In IDLE with is_br=1, the stall counter SHALL load STALL_CYCLES-1.
REQ-022 From IDLE with is_br=1, the next state SHALL be EVAL if STALL_CYCLES==1, else STALL.
REQ-023 In IDLE with is_br=0, all outputs except the counters SHALL be 0.
REQ-024 In STALL, stall_en SHALL be 1 and the counter SHALL decrement by 1 each cycle.
REQ-025 STALL SHALL transition to EVAL in the cycle the counter equals 1.
REQ-026 The total fixed stall SHALL be exactly STALL_CYCLES cycles from the first stall_en.
REQ-027 In EVAL with (flags_valid=1 or C==111), branch_done SHALL be 1 and take_branch SHALL equal cond_met, using the flags sampled that cycle.
REQ-028 In that same resolving EVAL cycle, stall_en SHALL be 0 and the next state SHALL be IDLE.
REQ-029 In EVAL with flags_valid=0 and C!=111, stall_en SHALL be 1, take_branch and branch_done SHALL be 0, and the FSM SHALL stay in EVAL for an unbounded wait.
REQ-030 On resolution, taken_cnt SHALL increment if take_branch=1, else not_taken_cnt SHALL increment.
REQ-031 Both counters SHALL saturate at all-ones and never wrap.
REQ-032 take_branch and branch_done SHALL never be 1 in any cycle other than a resolving EVAL cycle; take_branch=1 SHALL imply branch_done=1.
REQ-033 If is_br=0 while in STALL or EVAL (upstream squash), the FSM SHALL return to IDLE next cycle, with no output pulses and no counter update.
REQ-034 In that squash cycle, stall_en SHALL be 0.
REQ-035 flush=1 SHALL force stall_en, take_branch and branch_done to 0 that cycle and the next state to IDLE, with no counter update; flush has priority over every rule except rst.
REQ-036 A branch in decode the cycle after resolution SHALL start a new sequence from IDLE (back-to-back supported, no bubble cycle required).
REQ-037 opcode and C SHALL be sampled each cycle; a change of C mid-sequence while is_br=1 SHALL use the value present in the EVAL cycle.

Reset
REQ-038 While rst=1, stall_en, take_branch and branch_done SHALL be 0 regardless of inputs.
REQ-039 On a clock edge with rst=1, the state SHALL become IDLE and the stall counter, taken_cnt and not_taken_cnt SHALL become 0.
REQ-040 rst asserted mid-sequence SHALL abort the branch without a take_branch pulse.
REQ-041 rst SHALL have priority over flush and all other inputs.

Verification
REQ-042 STALL_CYCLES=1, opcode=C, C=001, flags=100, flags_valid=1 -> stall_en=1 for cycle 0; cycle 1 take_branch=1, branch_done=1; taken_cnt=1.
REQ-043 STALL_CYCLES=3, opcode=D, C=000, Z=1 -> stall_en=1 for cycles 0-2; cycle 3 branch_done=1, take_branch=0; not_taken_cnt=1.
REQ-044 STALL_CYCLES=1, C=011, flags_valid=0 for 4 cycles then 1 with N=1 -> stall_en=1 for cycles 0-4; take_branch pulses in cycle 5.
REQ-045 C=111 with flags_valid=0 -> resolves taken without waiting; flush in the STALL state (STALL_CYCLES=2) -> no pulse, counters unchanged, IDLE next.
REQ-046 CNT_W=2, 5 taken branches -> taken_cnt reads 3 (saturated); rst asserted in EVAL -> outputs 0 immediately and counters 0 next cycle.
